// File: rtl/axis_gpio_bank_if.sv
// Command/readback stream pair between the register fabric and the GPIO bank.
//   axis_wdata/axis_wvalid/axis_wready : command word stream (master -> slave)
//   axis_rdata/axis_rvalid/axis_rready : readback word stream (slave -> master)
interface axis_gpio_bank_if;
    logic [31:0] axis_wdata;
    logic        axis_wvalid;
    logic        axis_wready;
    logic [31:0] axis_rdata;
    logic        axis_rvalid;
    logic        axis_rready;

    modport master (
        output axis_wdata, axis_wvalid, axis_rready,
        input  axis_wready, axis_rdata, axis_rvalid
    );

    modport slave (
        input  axis_wdata, axis_wvalid, axis_rready,
        output axis_wready, axis_rdata, axis_rvalid
    );
endinterface

// File: rtl/axis_gpio_bank.sv
// GPIO controller, up to 48 pins seen as four 12-bit banks over a 32-bit
// command/readback stream pair. Per pin: 2-flop synchroniser, tick-based
// debounce filter, output/open-drain/alt0 pad modes, rise/fall edge detect
// with sticky pending bits, and a registered level IRQ.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   axis                command (wdata/wvalid/wready) and readback (rdata/rvalid/rready)
//   gpi_data            raw asynchronous pad inputs
//   gpo_data/_oe        pad output value / enable (combinational from mode/out/alt0)
//   gpio_altf0_valid    1 where the pin is in ALT0 mode
//   alt0_in             synchronised pad inputs for the alt function
//   alt0_out/_oe        alt function output value / enable
//   irq                 registered OR of all pending bits
module axis_gpio_bank #(
    parameter int unsigned         WIDTH        = 24,
    parameter logic [3*WIDTH-1:0]  DEF_CFG_GPIO = '0,
    parameter logic [WIDTH-1:0]    DEF_GPIO_OUT = '0,
    parameter int unsigned         DEB_DIV      = 1000,
    parameter int unsigned         DEB_LEN      = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    axis_gpio_bank_if.slave      axis,
    input  logic [WIDTH-1:0]     gpi_data,
    output logic [WIDTH-1:0]     gpo_data,
    output logic [WIDTH-1:0]     gpo_data_oe,
    output logic [WIDTH-1:0]     gpio_altf0_valid,
    output logic [WIDTH-1:0]     alt0_in,
    input  logic [WIDTH-1:0]     alt0_out,
    input  logic [WIDTH-1:0]     alt0_out_oe,
    output logic                 irq
);

    localparam int unsigned DIVW = $clog2(DEB_DIV);
    localparam int unsigned CNTW = 4;

    localparam logic [2:0] OP_OUT  = 3'd0;
    localparam logic [2:0] OP_SET  = 3'd1;
    localparam logic [2:0] OP_CLR  = 3'd2;
    localparam logic [2:0] OP_CFG  = 3'd3;
    localparam logic [2:0] OP_REN  = 3'd4;
    localparam logic [2:0] OP_FEN  = 3'd5;
    localparam logic [2:0] OP_ACK  = 3'd6;
    localparam logic [2:0] OP_RSEL = 3'd7;

    localparam logic [2:0] MODE_OUT  = 3'd1;
    localparam logic [2:0] MODE_ALT0 = 3'd2;
    localparam logic [2:0] MODE_DEB  = 3'd3;
    localparam logic [2:0] MODE_OD   = 3'd4;

    // Command field decode
    logic [2:0]  cmd_op;
    logic [1:0]  cmd_bank;
    logic [11:0] cmd_mask;
    logic [11:0] cmd_data;
    logic [7:0]  cmd_pin;
    logic        cmd_vld;

    assign cmd_op   = axis.axis_wdata[31:29];
    assign cmd_bank = axis.axis_wdata[25:24];
    assign cmd_mask = axis.axis_wdata[23:12];
    assign cmd_data = axis.axis_wdata[11:0];
    assign cmd_pin  = axis.axis_wdata[23:16];
    assign cmd_vld  = axis.axis_wvalid;

    logic unused_ok;
    assign unused_ok = ^{axis.axis_rready, axis.axis_wdata[28:26]};

    // Bank-aligned mask/data; bits landing above WIDTH fall off in the cast
    logic [WIDTH-1:0] wr_mask;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] wr_md;

    assign wr_mask = WIDTH'({36'd0, cmd_mask} << (12 * cmd_bank));
    assign wr_data = WIDTH'({36'd0, cmd_data} << (12 * cmd_bank));
    assign wr_md   = wr_mask & wr_data;

    // State
    logic [WIDTH-1:0]   out_q,   out_d;
    logic [3*WIDTH-1:0] mode_q,  mode_d;
    logic [WIDTH-1:0]   ren_q,   ren_d;
    logic [WIDTH-1:0]   fen_q,   fen_d;
    logic [WIDTH-1:0]   pend_q,  pend_d;
    logic [WIDTH-1:0]   sync1_q, sync2_q;
    logic [WIDTH-1:0]   filt_q,  filt_d;
    logic [WIDTH-1:0]   prev_q;
    logic [CNTW-1:0]    cnt_q [WIDTH];
    logic [CNTW-1:0]    cnt_d [WIDTH];
    logic [DIVW-1:0]    presc_q, presc_d;
    logic [1:0]         rd_bank_q, rd_bank_d;
    logic               rd_view_q, rd_view_d;
    logic               irq_q;

    logic               tick;
    logic [WIDTH-1:0]   edge_src;
    logic [WIDTH-1:0]   ack;

    // Debounce prescaler: one-cycle tick every DEB_DIV clocks
    assign tick    = (presc_q == DIVW'(DEB_DIV - 1));
    assign presc_d = tick ? '0 : presc_q + DIVW'(1);

    // Edge source: filtered level for debounced pins, synchronised level otherwise
    always_comb begin
        edge_src = sync2_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (mode_q[3*i +: 3] == MODE_DEB) begin
                edge_src[i] = filt_q[i];
            end
        end
    end

    // Command execution
    always_comb begin
        out_d     = out_q;
        mode_d    = mode_q;
        ren_d     = ren_q;
        fen_d     = fen_q;
        rd_bank_d = rd_bank_q;
        rd_view_d = rd_view_q;
        ack       = '0;
        if (cmd_vld) begin
            case (cmd_op)
                OP_OUT:  out_d = (out_q & ~wr_mask) | wr_md;
                OP_SET:  out_d = out_q | wr_md;
                OP_CLR:  out_d = out_q & ~wr_md;
                OP_CFG: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (cmd_pin == 8'(i)) begin
                            mode_d[3*i +: 3] = cmd_data[2:0];
                        end
                    end
                end
                OP_REN:  ren_d = (ren_q & ~wr_mask) | wr_md;
                OP_FEN:  fen_d = (fen_q & ~wr_mask) | wr_md;
                OP_ACK:  ack   = wr_md;
                OP_RSEL: begin
                    rd_bank_d = cmd_bank;
                    rd_view_d = cmd_data[0];
                end
                default: ;
            endcase
        end
    end

    // Sticky pending: a new edge beats a same-cycle ACK
    assign pend_d = (pend_q & ~ack)
                  | (edge_src & ~prev_q & ren_q)
                  | (~edge_src & prev_q & fen_q);

    // Per-pin debounce: DEB_LEN consecutive differing ticks accept the new level
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (tick) begin
                if (sync2_q[i] != filt_q[i]) begin
                    if (cnt_q[i] == CNTW'(DEB_LEN - 1)) begin
                        filt_d[i] = sync2_q[i];
                        cnt_d[i]  = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNTW'(1);
                    end
                end else begin
                    cnt_d[i] = '0;
                end
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= DEF_GPIO_OUT;
            mode_q    <= DEF_CFG_GPIO;
            ren_q     <= '0;
            fen_q     <= '0;
            pend_q    <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            filt_q    <= '0;
            prev_q    <= '0;
            presc_q   <= '0;
            rd_bank_q <= '0;
            rd_view_q <= 1'b0;
            irq_q     <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            out_q     <= out_d;
            mode_q    <= mode_d;
            ren_q     <= ren_d;
            fen_q     <= fen_d;
            pend_q    <= pend_d;
            sync1_q   <= gpi_data;
            sync2_q   <= sync1_q;
            filt_q    <= filt_d;
            prev_q    <= edge_src;
            presc_q   <= presc_d;
            rd_bank_q <= rd_bank_d;
            rd_view_q <= rd_view_d;
            irq_q     <= |pend_q;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Pad drive per mode; modes 000 and 101..111 are plain inputs
    always_comb begin
        gpo_data         = '0;
        gpo_data_oe      = '0;
        gpio_altf0_valid = '0;
        for (int i = 0; i < WIDTH; i++) begin
            case (mode_q[3*i +: 3])
                MODE_OUT: begin
                    gpo_data[i]    = out_q[i];
                    gpo_data_oe[i] = 1'b1;
                end
                MODE_ALT0: begin
                    gpo_data[i]         = alt0_out[i];
                    gpo_data_oe[i]      = alt0_out_oe[i];
                    gpio_altf0_valid[i] = 1'b1;
                end
                MODE_OD: begin
                    gpo_data_oe[i] = ~out_q[i];
                end
                default: ;
            endcase
        end
    end

    assign alt0_in = sync2_q;
    assign irq     = irq_q;

    // Readback: 48-bit zero-padded views so missing pins read as 0
    function automatic logic [11:0] bank_sel(input logic [47:0] v, input logic [1:0] b);
        logic [11:0] r;
        case (b)
            2'd0:    r = v[11:0];
            2'd1:    r = v[23:12];
            2'd2:    r = v[35:24];
            default: r = v[47:36];
        endcase
        return r;
    endfunction

    logic [47:0] out_w, edge_w, en_w, pend_w;
    assign out_w  = 48'(out_q);
    assign edge_w = 48'(edge_src);
    assign en_w   = 48'(ren_q | fen_q);
    assign pend_w = 48'(pend_q);

    assign axis.axis_rdata = {irq_q, 3'b000, rd_bank_q, 2'b00,
                              rd_view_q ? bank_sel(en_w, rd_bank_q)   : bank_sel(out_w, rd_bank_q),
                              rd_view_q ? bank_sel(pend_w, rd_bank_q) : bank_sel(edge_w, rd_bank_q)};
    assign axis.axis_wready = 1'b1;
    assign axis.axis_rvalid = 1'b1;

endmodule
